// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch front end: queue entry layout, FSM states, PC helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fetch_queue_pkg;

    typedef logic [31:0] DATA_BUS;

    // Every instruction is one 32-bit word; the fetch PC advances by this many bytes.
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        DATA_BUS pc;
        DATA_BUS instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Sequential successor; wraps naturally at 2^32.
    function automatic DATA_BUS next_pc(input DATA_BUS pc);
        return pc + DATA_BUS'(INSTR_BYTES);
    endfunction

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic DATA_BUS align_word(input DATA_BUS addr);
        return addr & ~DATA_BUS'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with push/pop/flush; pointers carry a wrap bit for full/empty.
// Latency: an entry written on a clock edge is visible at head right after that edge.
// Backpressure: none internally; push when full and pop when empty are ignored.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, push_dat    write one entry at the tail
//   pop               retire the head entry
//   flush             empty the buffer (wins over push/pop)
//   head              entry at the read pointer
//   count, empty, full occupancy status
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW:0]    rd_ptr;
    logic [AW:0]    wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset: nothing is read until the write pointer moves past it.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    // Same slot index but opposite wrap bits: the writer is a full lap ahead.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues imem word reads, queues in-order responses for decode.
// Latency: request handshake to out_valid is 1 cycle plus memory latency; queue head is visible right after the write.
// Backpressure: requests stop once queued + in-flight entries reach DEPTH, so a response always finds space.
//
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   halt                             level, stops new requests (in-flight responses still queue)
//   redirect_valid, redirect_pc      taken branch/jump from execute: flush and refetch
//   imem_req_valid/ready/addr        word read request to instruction memory
//   imem_rsp_valid/data              in-order response, cannot be stalled
//   out_valid/ready, out_pc/instr    queue head towards decode
//   stat_fetched, stat_discarded     only with FETCH_STATS_EN: pushed / dropped+flushed counters
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_VECTOR    = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_discarded
`endif
);

    // Outstanding and discard never exceed MAX_OUTSTANDING <= DEPTH, so they share the count width.
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);

    fetch_state_t   state;
    DATA_BUS        fetch_pc;
    DATA_BUS        rsp_pc;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  discard;

    fetch_entry_t   push_dat;
    fetch_entry_t   head;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic           fifo_full;

    logic           redirect_take;
    logic           req_fire;
    logic           rsp_drop;
    logic           push;
    logic           pop;
    logic           credit_ok;
    logic [CW-1:0]  rsp_dec;

    // Redirects before the first RUN cycle have nothing to flush and are ignored.
    assign redirect_take = redirect_valid && (state != BOOT);
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign rsp_dec       = {{(CW-1){1'b0}}, imem_rsp_valid};

    // A response is stale if it belongs to a request issued before a redirect,
    // including one landing in the redirect cycle itself.
    assign rsp_drop = imem_rsp_valid && (redirect_take || (discard != '0));
    assign push     = imem_rsp_valid && !rsp_drop;
    assign pop      = out_valid && out_ready && !redirect_take;

    // Reserve a queue slot for every in-flight request so responses never overflow.
    assign credit_ok = (({1'b0, fifo_count} + {1'b0, outstanding}) < {1'b0, DEPTH_C}) && !fifo_full;

    assign imem_req_valid = (state == RUN) && !redirect_valid && credit_ok && (outstanding < MAX_C);
    assign imem_req_addr  = fetch_pc;

    assign push_dat.pc    = rsp_pc;
    assign push_dat.instr = imem_rsp_data;

    assign out_valid = !fifo_empty;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (halt)  state <= HALTED;
                HALTED:  if (!halt) state <= RUN;
                default: state <= BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_VECTOR;
            rsp_pc      <= RESET_VECTOR;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + {{(CW-1){1'b0}}, req_fire} - rsp_dec;
            if (redirect_take) begin
                fetch_pc <= align_word(redirect_pc);
                rsp_pc   <= align_word(redirect_pc);
                // No request fires in a redirect cycle, so every survivor after
                // this cycle's response is stale.
                discard  <= outstanding - rsp_dec;
            end else begin
                if (req_fire) fetch_pc <= next_pc(fetch_pc);
                if (push)     rsp_pc   <= next_pc(rsp_pc);
                if (imem_rsp_valid && (discard != '0)) discard <= discard - {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (redirect_take),
        .head     (head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fetched   <= '0;
            stat_discarded <= '0;
        end else begin
            stat_fetched   <= stat_fetched + 32'(push);
            stat_discarded <= stat_discarded + 32'(rsp_drop)
                            + (redirect_take ? 32'(fifo_count) : 32'd0);
        end
    end
`endif

endmodule
